fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Pipeline-control block that tracks destination registers of in-flight instructions in EX, MEM and WB.
- Generates registered, EX-aligned operand-bypass selects (MEM-stage result / WB-stage result) for the EX operand mux.
- Detects load-use hazards in ID and stalls ID for one cycle while inserting a bubble into EX.
- Sits between decode and the EX operand mux.

Parameters:
- REG_W, 5, register index width
- NREGS, 32, architectural register count; index 0 is hard-wired zero

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1  in  REG_W  ID source register 1
- id_rs2  in  REG_W  ID source register 2
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  REG_W  ID destination register
- id_rd_wen  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load (result available only at WB)
- mem_stall  in  1  data memory busy; freezes EX/MEM/WB
- flush  in  1  EX redirect; kills the ID instruction
- stall_id  out  1  hold PC/IF/ID this cycle
- ex_valid  out  1  EX holds a valid instruction
- alu_bypass_rs1  out  1  EX rs1 takes MEM-stage result
- alu_bypass_rs2  out  1  EX rs2 takes MEM-stage result
- dmem_bypass_rs1  out  1  EX rs1 takes WB-stage result
- dmem_bypass_rs2  out  1  EX rs2 takes WB-stage result

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Stage entries: each of EX, MEM and WB holds {valid, rd, wen, is_load}.
- Reset: all entries invalid, all bypass outputs 0, ex_valid=0.
- Effective write: valid & wen & rd!=0. rd==0 never matches.
- Hazard checks (combinational in ID, on ID inputs vs EX and MEM entries):
  - match_ex_rsN = id_valid & id_rsN_used & EX effective write & EX.rd==id_rsN
  - match_mem_rsN: same, against the MEM entry
  - load_use = match_ex_rs1 | match_ex_rs2, where the EX entry has is_load=1
- stall_id = mem_stall | (load_use & !flush). This is combinational.
- Advance (mem_stall=0), every cycle:
  - WB<=MEM; MEM<=EX
  - EX<=bubble if flush | load_use | !id_valid; otherwise EX<=ID fields
- Bypass registers, loaded together with EX:
  - alu_bypass_rsN <= match_ex_rsN & !EX.is_load
  - dmem_bypass_rsN <= match_mem_rsN & !match_ex_rsN (the younger producer wins)
  - On a bubble, all four bypass registers are cleared.
- Freeze (mem_stall=1): all entries and outputs hold; flush is ignored.
- WB-entry matches are not forwarded. The regfile provides write-before-read.
- Latency: selects are valid in the same cycle the consumer is in EX (registered from ID, 1 cycle).
- Load-use sequence: stall exactly one cycle. Next cycle the load is in MEM and the consumer gets dmem_bypass.
- Reset mid-operation: all in-flight entries are discarded immediately (asynchronous).
- flush & load_use together: flush wins, the bubble is inserted, and stall_id is not raised by load_use.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN
- With the macro, add three outputs, each 32 bits, wrap-around, reset 0:
  - perf_loaduse_cnt: +1 per cycle with load_use & !flush & !mem_stall
  - perf_alu_fwd_cnt: +1 per advancing cycle where any alu_bypass bit is being set
  - perf_dmem_fwd_cnt: the same for the dmem_bypass bits
- Without the macro: the ports and counters are absent, with zero logic.

Decomposition:
- Package fwd_pkg:
  - stage_entry_t struct {valid, rd, wen, is_load}
  - REG_W, X0 constant
  - function rd_match(entry, rs, used)
- Sub-module fwd_stage_reg: one stage_entry_t register with hold/bubble/load controls. It is instantiated for EX, MEM and WB.

Test Plan:
- Back-to-back dependency:
  - add x5 then sub x6,x5,x7 → second in EX with alu_bypass_rs1=1 and all other selects 0.
  - No stall.
- Distance-2 dependency with an independent instruction between → consumer in EX with dmem_bypass_rs1=1 and alu_bypass_rs1=0.
- Load-use:
  - ld x8 then add x9,x8,x8 → stall_id=1 for exactly 1 cycle, one bubble (ex_valid=0).
  - Then the consumer in EX has dmem_bypass_rs1=dmem_bypass_rs2=1.
- Double producer: addi x3 twice, then use x3 → alu_bypass_rs1=1 and dmem_bypass_rs1=0.
- x0 and unused source:
  - Writes to x0 → no bypass.
  - rs2_used=0 matching rd → alu_bypass_rs2=0.
- mem_stall held 3 cycles → outputs and entries frozen. Then flush coincident with load_use → bubble, stall_id=0, and rst_n pulse mid-stream clears everything.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / hazard unit.
// A stage entry describes the destination of the instruction occupying a
// pipeline stage.
package fwd_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] X0 = '0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             is_load;
    } stage_entry_t;

    // An entry can only produce a value if it is live, writes a register
    // and that register is not the hard-wired zero.
    function automatic logic eff_write(input stage_entry_t e);
        return e.valid & e.wen & (e.rd != X0);
    endfunction

    // True when a source operand that is actually read is produced by e.
    function automatic logic rd_match(input stage_entry_t e,
                                      input logic [REG_W-1:0] rs,
                                      input logic used);
        return used & eff_write(e) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage entry register.
// hold has priority over bubble; bubble loads an all-zero (invalid) entry.
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  stage_entry_t d,
    output stage_entry_t q
);

    stage_entry_t entry_d;
    stage_entry_t entry_q;

    // Next-entry select: freeze, squash, or take the upstream entry.
    always_comb begin
        entry_d = entry_q;
        if (!hold) begin
            if (bubble) begin
                entry_d = '0;
            end else begin
                entry_d = d;
            end
        end
    end

    // Entry register; reset discards whatever was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-bypass select generation and load-use stall detection.
// Tracks the destinations of the instructions in EX, MEM and WB and
// registers EX-aligned bypass selects alongside the EX entry.
// Optional macro FWD_HAZARD_PERF_EN adds three 32-bit event counters.
//
// Pipeline control: mem_stall=1 freezes every entry and every registered
// output (flush has no effect in that cycle). With mem_stall=0 all stages
// advance each cycle; EX receives a bubble on flush, load-use or an empty ID.
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_wen,
    input  logic             id_is_load,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic             alu_bypass_rs1,
    output logic             alu_bypass_rs2,
    output logic             dmem_bypass_rs1,
    output logic             dmem_bypass_rs2
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_loaduse_cnt,
    output logic [31:0]      perf_alu_fwd_cnt,
    output logic [31:0]      perf_dmem_fwd_cnt
`endif
);

    import fwd_pkg::*;

    // The stage entry type is sized by the package; the register file must
    // cover the full index space so every index names a real register.
    if (REG_W != fwd_pkg::REG_W || NREGS != (1 << REG_W)) begin : g_cfg_err
        $error("fwd_hazard_unit: REG_W/NREGS inconsistent with fwd_pkg");
    end

    stage_entry_t ex_q;
    stage_entry_t mem_q;
    stage_entry_t wb_q;
    stage_entry_t id_entry;

    logic match_ex_rs1;
    logic match_ex_rs2;
    logic match_mem_rs1;
    logic match_mem_rs2;
    logic load_use;
    logic advance;
    logic ex_bubble;

    logic alu_bypass_rs1_d,  alu_bypass_rs1_q;
    logic alu_bypass_rs2_d,  alu_bypass_rs2_q;
    logic dmem_bypass_rs1_d, dmem_bypass_rs1_q;
    logic dmem_bypass_rs2_d, dmem_bypass_rs2_q;

    // ID operands against the EX and MEM producers; load-use when EX holds a load.
    always_comb begin
        match_ex_rs1  = id_valid & rd_match(ex_q,  id_rs1, id_rs1_used);
        match_ex_rs2  = id_valid & rd_match(ex_q,  id_rs2, id_rs2_used);
        match_mem_rs1 = id_valid & rd_match(mem_q, id_rs1, id_rs1_used);
        match_mem_rs2 = id_valid & rd_match(mem_q, id_rs2, id_rs2_used);
        load_use      = (match_ex_rs1 | match_ex_rs2) & ex_q.is_load;
    end

    // flush takes priority over load-use: the ID instruction dies anyway.
    assign stall_id  = mem_stall | (load_use & ~flush);
    assign advance   = ~mem_stall;
    assign ex_bubble = flush | load_use | ~id_valid;

    // Entry presented to EX when ID is accepted.
    always_comb begin
        id_entry         = '0;
        id_entry.valid   = 1'b1;
        id_entry.rd      = id_rd;
        id_entry.wen     = id_rd_wen;
        id_entry.is_load = id_is_load;
    end

    fwd_stage_reg u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (mem_stall),
        .bubble (ex_bubble),
        .d      (id_entry),
        .q      (ex_q)
    );

    fwd_stage_reg u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (mem_stall),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    fwd_stage_reg u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (mem_stall),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // WB producers reach the consumer through the regfile's write-before-read,
    // and MEM's load flag never matters once the load has left EX.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{wb_q, mem_q.is_load};

    // Bypass selects load with EX; the younger (EX) producer beats MEM.
    always_comb begin
        alu_bypass_rs1_d  = alu_bypass_rs1_q;
        alu_bypass_rs2_d  = alu_bypass_rs2_q;
        dmem_bypass_rs1_d = dmem_bypass_rs1_q;
        dmem_bypass_rs2_d = dmem_bypass_rs2_q;
        if (advance) begin
            if (ex_bubble) begin
                alu_bypass_rs1_d  = 1'b0;
                alu_bypass_rs2_d  = 1'b0;
                dmem_bypass_rs1_d = 1'b0;
                dmem_bypass_rs2_d = 1'b0;
            end else begin
                alu_bypass_rs1_d  = match_ex_rs1 & ~ex_q.is_load;
                alu_bypass_rs2_d  = match_ex_rs2 & ~ex_q.is_load;
                dmem_bypass_rs1_d = match_mem_rs1 & ~match_ex_rs1;
                dmem_bypass_rs2_d = match_mem_rs2 & ~match_ex_rs2;
            end
        end
    end

    // Bypass select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_bypass_rs1_q  <= 1'b0;
            alu_bypass_rs2_q  <= 1'b0;
            dmem_bypass_rs1_q <= 1'b0;
            dmem_bypass_rs2_q <= 1'b0;
        end else begin
            alu_bypass_rs1_q  <= alu_bypass_rs1_d;
            alu_bypass_rs2_q  <= alu_bypass_rs2_d;
            dmem_bypass_rs1_q <= dmem_bypass_rs1_d;
            dmem_bypass_rs2_q <= dmem_bypass_rs2_d;
        end
    end

    assign ex_valid        = ex_q.valid;
    assign alu_bypass_rs1  = alu_bypass_rs1_q;
    assign alu_bypass_rs2  = alu_bypass_rs2_q;
    assign dmem_bypass_rs1 = dmem_bypass_rs1_q;
    assign dmem_bypass_rs2 = dmem_bypass_rs2_q;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_loaduse_cnt_d,  perf_loaduse_cnt_q;
    logic [31:0] perf_alu_fwd_cnt_d,  perf_alu_fwd_cnt_q;
    logic [31:0] perf_dmem_fwd_cnt_d, perf_dmem_fwd_cnt_q;

    // Event counters: real stalls, and advancing cycles that set a select.
    always_comb begin
        perf_loaduse_cnt_d  = perf_loaduse_cnt_q
                            + 32'(load_use & ~flush & ~mem_stall);
        perf_alu_fwd_cnt_d  = perf_alu_fwd_cnt_q
                            + 32'(advance & (alu_bypass_rs1_d | alu_bypass_rs2_d));
        perf_dmem_fwd_cnt_d = perf_dmem_fwd_cnt_q
                            + 32'(advance & (dmem_bypass_rs1_d | dmem_bypass_rs2_d));
    end

    // Counter registers, free-running with wrap-around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loaduse_cnt_q  <= '0;
            perf_alu_fwd_cnt_q  <= '0;
            perf_dmem_fwd_cnt_q <= '0;
        end else begin
            perf_loaduse_cnt_q  <= perf_loaduse_cnt_d;
            perf_alu_fwd_cnt_q  <= perf_alu_fwd_cnt_d;
            perf_dmem_fwd_cnt_q <= perf_dmem_fwd_cnt_d;
        end
    end

    assign perf_loaduse_cnt  = perf_loaduse_cnt_q;
    assign perf_alu_fwd_cnt  = perf_alu_fwd_cnt_q;
    assign perf_dmem_fwd_cnt = perf_dmem_fwd_cnt_q;
`else
    // No counters in this build.
`endif

endmodule
